// File: rtl/delay_pkg.sv
// Shared types and helpers for the variable-length delay line.
// Holds the fill/run state encoding and the log2 used to size the delay code.
package delay_pkg;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      RUN  = 1'b1
   } fill_state_t;

   // Ceiling log2, usable in constant expressions (n >= 2).
   function automatic int clog2_f(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/delay_fill_ctr.sv
// Fill counter and FILL/RUN state machine for the delay line.
// Reports primed once the pipe holds enough enabled samples for the active delay.
module delay_fill_ctr
   import delay_pkg::*;
#(
   parameter int DW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          load,
   input  logic [DW-1:0] cfg,
   input  logic [DW-1:0] act_delay,
   output logic          primed
);

   fill_state_t   state_r;
   fill_state_t   state_s;
   logic [DW:0]   cnt_r;
   logic [DW:0]   cnt_s;
   logic [DW:0]   cnt_inc_s;
   logic [DW:0]   target_s;

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= FILL;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state: load restarts the fill using the new code; an enabled
   // FILL edge counts toward d+1.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      cnt_inc_s = cnt_r + {{DW{1'b0}}, 1'b1};
      target_s  = {1'b0, act_delay} + {{DW{1'b0}}, 1'b1};
      if (load) begin
         cnt_s = en ? {{DW{1'b0}}, 1'b1} : {(DW+1){1'b0}};
         if (en && (cfg == {DW{1'b0}})) begin
            state_s = RUN;
         end else begin
            state_s = FILL;
         end
      end else if (en) begin
         case (state_r)
            FILL: begin
               cnt_s = cnt_inc_s;
               if (cnt_inc_s == target_s) begin
                  state_s = RUN;
               end else begin
                  state_s = FILL;
               end
            end
            RUN: begin
               state_s = RUN;
            end
            default: begin
               state_s = FILL;
               cnt_s   = {(DW+1){1'b0}};
            end
         endcase
      end else begin
         state_s = state_r;
         cnt_s   = cnt_r;
      end
   end

   assign primed = (state_r == RUN);

endmodule

// File: rtl/delay_line_var.sv
// Variable-length delay line: MAX_DEPTH data/valid stages with a runtime-
// selectable tap; output is a direct mux of the active stage.
module delay_line_var
   import delay_pkg::*;
#(
   parameter  int DATA_W        = 16,
   parameter  int MAX_DEPTH     = 8,
   parameter  int DEFAULT_DELAY = 0,
   localparam int DW            = clog2_f(MAX_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic [DW-1:0]     delay_cfg,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              primed
);

   localparam logic [DW-1:0] DEF_CODE = DW'(DEFAULT_DELAY);

   logic [DATA_W-1:0]    data_r [MAX_DEPTH];
   logic [MAX_DEPTH-1:0] vld_r;
   logic [DW-1:0]        act_r;

   // Data stages shift on enable only; load never clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_DEPTH; i++) begin
            data_r[i] <= '0;
         end
      end else if (en) begin
         data_r[0] <= data_in;
         for (int i = 1; i < MAX_DEPTH; i++) begin
            data_r[i] <= data_r[i-1];
         end
      end
   end

   // Valid bits: load flushes everything older than the load edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_r <= '0;
      end else if (load) begin
         vld_r <= {{(MAX_DEPTH-1){1'b0}}, (valid_in & en)};
      end else if (en) begin
         vld_r <= {vld_r[MAX_DEPTH-2:0], valid_in};
      end
   end

   // Active delay code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_r <= DEF_CODE;
      end else if (load) begin
         act_r <= delay_cfg;
      end
   end

   delay_fill_ctr #(
      .DW(DW)
   ) u_fill_ctr (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .cfg      (delay_cfg),
      .act_delay(act_r),
      .primed   (primed)
   );

   assign data_out  = data_r[act_r];
   assign valid_out = vld_r[act_r];

endmodule

// File: doc/delay_line_var.md
DELAY_LINE_VAR -- requirements
Module: delay_line_var

Interface
REQ-001 Parameter DATA_W, default 16, width of data_in/data_out.
REQ-002 Parameter MAX_DEPTH, default 8, number of delay stages; power of two, 2..64.
REQ-003 Parameter DEFAULT_DELAY, default 0, active delay code after reset; 0..MAX_DEPTH-1.
REQ-004 Local constant DW = log2(MAX_DEPTH), width of delay_cfg.
REQ-005 Reset is asynchronous and active-high; the block has one clock, port clk.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 en  input  1  shift enable; 0 freezes all state.
REQ-009 load  input  1  one-cycle pulse; latch delay_cfg as the new active delay code.
REQ-010 delay_cfg  input  DW  delay code d; total latency d+1 enabled cycles.
REQ-011 data_in  input  DATA_W  sample entering stage 0.
REQ-012 valid_in  input  1  qualifies data_in.
REQ-013 data_out  output  DATA_W  content of stage[active delay code].
REQ-014 valid_out  output  1  valid bit of stage[active delay code].
REQ-015 primed  output  1  high when the pipe is filled to the active delay (state RUN).

Function
REQ-016 Stages 0..MAX_DEPTH-1 hold data plus a valid bit; on an edge with en=1, stage0 <= {data_in, valid_in} and stage[i] <= stage[i-1].
REQ-017 On an edge with en=0, stages, valid bits, counter, state and active delay hold, except under load (REQ-021).
REQ-018 data_out/valid_out are a combinational mux of stage[active delay code]; no extra register.
REQ-019 Latency: a sample captured at an enabled edge appears on data_out after the (d+1)-th enabled edge, counting the capture edge; d=0 gives a one-cycle delay.
REQ-020 FSM states FILL and RUN; a fill counter of width DW+1 increments on each enabled edge in FILL; FILL->RUN when the counter reaches d+1; RUN holds until load or rst.
REQ-021 load=1 at an edge, regardless of en: active delay <= delay_cfg; state <= FILL; all valid bits cleared except stage0 valid <= valid_in & en; counter <= en ? 1 : 0; data stages shift only if en=1.
REQ-022 If load sets counter to 1 and d=0, the state moves to RUN at that same edge.
REQ-023 After load, valid_out never shows a sample captured before the load edge.
REQ-024 Data stages are not cleared by load; stale data may appear on data_out only with valid_out=0.
REQ-025 primed = (state == RUN).

Reset
REQ-026 On rst=1, immediately and without a clock edge: all data stages 0, all valid bits 0, data_out 0, valid_out 0, primed 0, counter 0, state FILL, active delay DEFAULT_DELAY.
REQ-027 rst overrides load and en; the first enabled edge after rst deasserts behaves as a fresh fill.

Structure
REQ-028 Shared package delay_pkg holds the FILL/RUN state enum and the log2 helper used for DW.
REQ-029 Sub-module delay_fill_ctr contains the fill counter and FSM (inputs en, load, active delay code; output primed); the stage array and output mux stay in the top.

Verification (DATA_W=16, MAX_DEPTH=8, DEFAULT_DELAY=0)
REQ-030 Release reset, en=1, data_in 0x0001, 0x0002, ... with valid_in=1 -> data_out equals the previous cycle's data_in; primed=1 after the first edge.
REQ-031 load with delay_cfg=3, en=1, data_in ramp 0x0010 onward -> valid_out=0 for 3 edges; 0x0010 appears with valid_out=1 after the 4th edge, with primed rising on that same edge.
REQ-032 Drop en for 5 cycles mid-stream -> data_out, valid_out, primed and counter are unchanged for all 5 cycles; the stream resumes without a lost or duplicated sample.
REQ-033 Stream at d=7, then load delay_cfg=2 -> valid_out=0 on the next cycle, then the first post-load sample appears after 3 enabled edges; no pre-load sample is ever reported valid.
REQ-034 Assert rst asynchronously mid-FILL at d=5 -> all outputs go to 0 before the next edge; after release the latency is 1 cycle (DEFAULT_DELAY).
REQ-035 load with delay_cfg=7 and en=1 on the same edge, valid_in=1, data 0xABCD -> 0xABCD appears with valid_out=1 after the 8th enabled edge, counting the load edge.
